inst_fetch_queue: RTL and testbench

//  Consumer side of the program-counter stream. Generates sequential fetch addresses,

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_queue.sv | 58 +++++
 rtl/inst_fetch_queue.sv | 86 ++++++++
 tb/tb_inst_fetch_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM state encoding and word-alignment constants shared by the fetch queue
package fetch_pkg;
    typedef enum logic [1:0] {INIT, FETCH, FULL, DRAIN} fetch_state_t;
    localparam int WORD_BYTES = 4;
    // Wide enough for any address width; users size-cast it down to ADDR_W.
    localparam logic [63:0] ALIGN_MASK = ~64'(WORD_BYTES - 1);
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, inst} pairs with flush and a registered head
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                empties the queue; same-cycle push/pop ignored
//   push, push_pc/inst   write one entry (dropped when full)
//   pop                  remove the head entry (dropped when empty)
//   count                current occupancy
//   head_valid/pc/inst   head entry; pc/inst hold their last value when empty
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic [ADDR_W-1:0]       push_pc,
    input  logic [DATA_W-1:0]       push_inst,
    input  logic                    pop,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    head_valid,
    output logic [ADDR_W-1:0]       head_pc,
    output logic [DATA_W-1:0]       head_inst
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [PW:0] count_nxt;
    logic do_push, do_pop, head_from_push;
    assign do_pop = pop && count != '0;
    assign do_push = push && count != FULL_CNT;
    assign count_nxt = count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    assign rd_nxt = rd_ptr + PW'(do_pop);
    // The incoming word becomes the head when it lands in an empty queue, or when the
    // only resident entry leaves on the same edge.
    assign head_from_push = do_push && count == (PW+1)'(do_pop);
    assign head_valid = count != '0;
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= {push_pc, push_inst};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            {head_pc, head_inst} <= '0;
        end else if (flush) begin
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_nxt;
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_ptr + PW'(do_push);
            if (count_nxt != '0) {head_pc, head_inst} <= head_from_push ? {push_pc, push_inst} : mem[rd_nxt];
        end
    end
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential instruction fetcher with single-outstanding memory reads and a decode queue
//   CLK, MasterReset_L        clock, asynchronous active-low reset
//   startPC                   first fetch address after reset release
//   Redirect, RedirectPC      flush and restart fetch at RedirectPC
//   MemReq, MemAddr           read request to instruction memory (held until MemAck)
//   MemAck, MemRData          request accepted, data valid the same cycle
//   InstValid, Inst, InstPC   queue head to decode
//   InstReady                 decode accepts the head this cycle
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              MasterReset_L,
    input  logic [ADDR_W-1:0] startPC,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    output logic              InstValid,
    output logic [DATA_W-1:0] Inst,
    output logic [ADDR_W-1:0] InstPC,
    input  logic              InstReady
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(ALIGN_MASK);
    fetch_state_t state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, target, redir_pc;
    logic [CW-1:0] count;
    logic req, ack, pending, flush, push, pop;
    assign redir_pc = RedirectPC & MASK;
    // Request depends only on registered state, so once raised it cannot drop before the
    // ack: the count can only fall while waiting, and DRAIN keeps it up regardless.
    assign req = (state == FETCH && count != FULL_CNT) || state == DRAIN;
    assign ack = req && MemAck;
    assign pending = req && !MemAck;
    assign flush = Redirect && state != INIT;
    assign push = ack && state == FETCH && !flush;
    assign pop = InstValid && InstReady && !flush;
    assign MemReq = req;
    assign MemAddr = fetch_pc;
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = FETCH;
            FETCH:   state_nxt = Redirect ? (pending ? DRAIN : FETCH) : (count == FULL_CNT ? FULL : FETCH);
            FULL:    state_nxt = (Redirect || count != FULL_CNT) ? FETCH : FULL;
            DRAIN:   state_nxt = MemAck ? FETCH : DRAIN;
            default: state_nxt = INIT;
        endcase
    end
    always_ff @(posedge CLK or negedge MasterReset_L) begin
        if (!MasterReset_L) begin
            state <= INIT;
            fetch_pc <= '0;
            target <= '0;
        end else begin
            state <= state_nxt;
            if (flush) target <= redir_pc;
            // In DRAIN the outstanding address stays on MemAddr; the newest target wins on ack.
            if (state == INIT) fetch_pc <= startPC & MASK;
            else if (state == DRAIN) fetch_pc <= MemAck ? (Redirect ? redir_pc : target) : fetch_pc;
            else if (Redirect && !pending) fetch_pc <= redir_pc;
            else if (ack) fetch_pc <= fetch_pc + ADDR_W'(WORD_BYTES);
        end
    end
    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_queue (
        .clk(CLK),
        .rst_n(MasterReset_L),
        .flush(flush),
        .push(push),
        .push_pc(fetch_pc),
        .push_inst(MemRData),
        .pop(pop),
        .count(count),
        .head_valid(InstValid),
        .head_pc(InstPC),
        .head_inst(Inst)
    );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed checks of fetch sequencing, back-pressure, delayed acks, redirects and reset
module tb_inst_fetch_queue;
    logic        CLK = 1'b0;
    logic        MasterReset_L;
    logic [31:0] startPC;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        InstValid;
    logic [31:0] Inst;
    logic [31:0] InstPC;
    logic        InstReady;
    logic        auto_ack, man_ack;
    int          n_checks = 0, n_fail = 0, ack_cnt = 0, base;
    logic [31:0] last_ack = '0;

    inst_fetch_queue dut (
        .CLK(CLK), .MasterReset_L(MasterReset_L), .startPC(startPC),
        .Redirect(Redirect), .RedirectPC(RedirectPC),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemRData(MemRData),
        .InstValid(InstValid), .Inst(Inst), .InstPC(InstPC), .InstReady(InstReady)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5a5a_0000;
    endfunction

    assign MemRData = word_at(MemAddr);
    assign MemAck = auto_ack ? MemReq : man_ack;

    always @(posedge CLK)
        if (MemReq && MemAck) begin
            ack_cnt <= ack_cnt + 1;
            last_ack <= MemAddr;
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        MasterReset_L = 1'b0;
        step();
        MasterReset_L = 1'b1;
    endtask

    initial begin
        MasterReset_L = 1'b0;
        startPC = 32'h0040_0000;
        Redirect = 1'b0;
        RedirectPC = '0;
        InstReady = 1'b1;
        auto_ack = 1'b1;
        man_ack = 1'b0;
        step();
        check("rst_memreq", 32'(MemReq), 0);
        check("rst_valid", 32'(InstValid), 0);
        check("rst_addr", MemAddr, 0);
        check("rst_inst", Inst, 0);
        check("rst_pc", InstPC, 0);
        MasterReset_L = 1'b1;

        // streaming: one instruction per cycle after two-cycle startup
        step();
        check("s_addr0", MemAddr, 32'h0040_0000);
        check("s_req0", 32'(MemReq), 1);
        check("s_valid0", 32'(InstValid), 0);
        step();
        for (int k = 0; k < 8; k++) begin
            check("s_valid", 32'(InstValid), 1);
            check("s_pc", InstPC, 32'h0040_0000 + 32'(4 * k));
            check("s_inst", Inst, word_at(32'h0040_0000 + 32'(4 * k)));
            step();
        end

        // back-pressure: exactly DEPTH acks then FULL, one pop frees one slot
        InstReady = 1'b0;
        reset_dut();
        base = ack_cnt;
        repeat (10) step();
        check("f_acks4", 32'(ack_cnt - base), 4);
        check("f_req", 32'(MemReq), 0);
        check("f_valid", 32'(InstValid), 1);
        check("f_head", InstPC, 32'h0040_0000);
        InstReady = 1'b1;
        step();
        InstReady = 1'b0;
        check("f_pop", InstPC, 32'h0040_0004);
        repeat (5) step();
        check("f_acks5", 32'(ack_cnt - base), 5);
        check("f_last", last_ack, 32'h0040_0010);
        check("f_req2", 32'(MemReq), 0);
        InstReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("f_seq", InstPC, 32'h0040_0004 + 32'(4 * k));
            check("f_seqv", 32'(InstValid), 1);
            step();
        end

        // delayed ack: request holds for three cycles
        auto_ack = 1'b0;
        reset_dut();
        step();
        for (int k = 0; k < 3; k++) begin
            check("d_req", 32'(MemReq), 1);
            check("d_addr", MemAddr, 32'h0040_0000);
            check("d_valid", 32'(InstValid), 0);
            if (k < 2) step();
        end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("d_valid1", 32'(InstValid), 1);
        check("d_pc", InstPC, 32'h0040_0000);
        check("d_inst", Inst, word_at(32'h0040_0000));
        check("d_next", MemAddr, 32'h0040_0004);

        // redirect while request to 0x08 is pending -> drain and discard
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("r_pend", MemAddr, 32'h0040_0008);
        check("r_head", InstPC, 32'h0040_0004);
        Redirect = 1'b1;
        RedirectPC = 32'h0040_0100;
        step();
        Redirect = 1'b0;
        check("r_flush", 32'(InstValid), 0);
        check("r_hold_req", 32'(MemReq), 1);
        check("r_hold_addr", MemAddr, 32'h0040_0008);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("r_discard", 32'(InstValid), 0);
        check("r_tgt", MemAddr, 32'h0040_0100);
        check("r_tgt_req", 32'(MemReq), 1);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("r_tgt_pc", InstPC, 32'h0040_0100);
        check("r_tgt_inst", Inst, word_at(32'h0040_0100));

        // repeated redirects while draining -> newest target used
        Redirect = 1'b1;
        RedirectPC = 32'h0040_0200;
        step();
        RedirectPC = 32'h0040_0300;
        step();
        RedirectPC = 32'h0040_0400;
        step();
        Redirect = 1'b0;
        check("m_hold", MemAddr, 32'h0040_0104);
        check("m_flush", 32'(InstValid), 0);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("m_tgt", MemAddr, 32'h0040_0400);
        check("m_empty", 32'(InstValid), 0);

        // redirect in the ack cycle, unaligned target, and address wrap
        InstReady = 1'b0;
        man_ack = 1'b1;
        step();
        check("a_valid", 32'(InstValid), 1);
        check("a_pc", InstPC, 32'h0040_0400);
        Redirect = 1'b1;
        RedirectPC = 32'h0040_0103;
        step();
        check("a_flush", 32'(InstValid), 0);
        check("a_align", MemAddr, 32'h0040_0100);
        check("a_req", 32'(MemReq), 1);
        RedirectPC = 32'hffff_fffc;
        step();
        Redirect = 1'b0;
        check("w_addr", MemAddr, 32'hffff_fffc);
        check("w_empty", 32'(InstValid), 0);
        step();
        man_ack = 1'b0;
        check("w_pc", InstPC, 32'hffff_fffc);
        check("w_inst", Inst, word_at(32'hffff_fffc));
        check("w_wrap", MemAddr, 32'h0000_0000);

        // asynchronous reset mid-request
        #3;
        MasterReset_L = 1'b0;
        #1;
        check("x_req", 32'(MemReq), 0);
        check("x_valid", 32'(InstValid), 0);
        check("x_addr", MemAddr, 0);
        check("x_pc", InstPC, 0);
        check("x_inst", Inst, 0);
        startPC = 32'h0040_0052;
        step();
        MasterReset_L = 1'b1;
        step();
        check("x_restart", MemAddr, 32'h0040_0050);
        check("x_rreq", 32'(MemReq), 1);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("x_head", InstPC, 32'h0040_0050);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
